// File: rtl/divider_ctrl.sv
// divider_ctrl: sequential 32/32 restoring divider with a four-state control FSM.
//
// A division starts when Start is seen in IDLE. The divider spends one cycle in
// LOAD, 32 cycles in RUN (one quotient bit per cycle), and one cycle in DONE.
// A zero divisor skips RUN: LOAD goes straight to DONE.
//
// Ports
//   clk            rising-edge clock
//   Reset          synchronous, active-high reset
//   Start          request a division; only looked at in IDLE
//   Dividend_in    dividend operand, latched at the end of LOAD
//   Divisor_in     divisor operand, latched at the end of LOAD
//   W_ctrl         divisor-register write strobe, high in LOAD
//   Busy           high in LOAD and RUN
//   Ready          one-cycle completion pulse, high in DONE
//   Quotient_out   quotient, updated on entry to DONE and held
//   Remainder_out  remainder, updated on entry to DONE and held
//   Div_by_zero    the latched divisor was zero; cleared when the next LOAD begins
//
// Configuration
//   DIV_SIGNED_EN  when defined, operands are two's complement. The magnitudes
//                  are divided. The quotient is negated when the operand signs
//                  differ, and the remainder takes the dividend's sign.
//                  When undefined, the divider is unsigned and has no sign logic.
//
// state | meaning
// IDLE  | waiting for Start
// LOAD  | latch operands, initialise {R,Q} and step counter
// RUN   | 32 restoring steps, one per cycle
// DONE  | results valid, Ready pulse

module divider_ctrl (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] Dividend_in,
  input  logic [31:0] Divisor_in,
  output logic        W_ctrl,
  output logic        Busy,
  output logic        Ready,
  output logic [31:0] Quotient_out,
  output logic [31:0] Remainder_out,
  output logic        Div_by_zero
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [63:0] work;        // {R, Q}
  logic [31:0] divisor_q;
  logic [5:0]  cnt;

  logic [31:0] dividend_mag, divisor_mag;
  logic [32:0] r_sh;
  logic [33:0] diff;
  logic [63:0] work_step;
  logic [31:0] q_fin, r_fin;

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;

  assign dividend_mag = Dividend_in[31] ? (32'd0 - Dividend_in) : Dividend_in;
  assign divisor_mag  = Divisor_in[31]  ? (32'd0 - Divisor_in)  : Divisor_in;
  assign q_fin = neg_q ? (32'd0 - work_step[31:0])  : work_step[31:0];
  assign r_fin = neg_r ? (32'd0 - work_step[63:32]) : work_step[63:32];
`else
  assign dividend_mag = Dividend_in;
  assign divisor_mag  = Divisor_in;
  assign q_fin = work_step[31:0];
  assign r_fin = work_step[63:32];
`endif

  // One restoring step. The shifted partial remainder can be 33 bits wide when
  // the divisor is above 2^31. The subtraction therefore keeps an extra borrow
  // bit so that large divisors are still compared correctly.
  always_comb begin
    r_sh      = work[63:31];
    diff      = {1'b0, r_sh} - {2'b00, divisor_q};
    work_step = {r_sh[31:0], work[30:0], 1'b0};
    if (!diff[33])
      work_step = {diff[31:0], work[30:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (Reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    W_ctrl    = 1'b0;
    Busy      = 1'b0;
    Ready     = 1'b0;
    case (state)
      IDLE: if (Start) state_nxt = LOAD;
      LOAD: begin
        W_ctrl    = 1'b1;
        Busy      = 1'b1;
        state_nxt = (Divisor_in == 32'd0) ? DONE : RUN;
      end
      RUN: begin
        Busy = 1'b1;
        if (cnt == 6'd31) state_nxt = DONE;
      end
      DONE: begin
        Ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      work          <= '0;
      divisor_q     <= '0;
      cnt           <= '0;
      Quotient_out  <= '0;
      Remainder_out <= '0;
      Div_by_zero   <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (Start) Div_by_zero <= 1'b0;
        LOAD: begin
          divisor_q <= divisor_mag;
          work      <= {32'd0, dividend_mag};
          cnt       <= '0;
`ifdef DIV_SIGNED_EN
          neg_q     <= Dividend_in[31] ^ Divisor_in[31];
          neg_r     <= Dividend_in[31];
`endif
          if (Divisor_in == 32'd0) begin
            Div_by_zero   <= 1'b1;
            Quotient_out  <= 32'hFFFF_FFFF;
            Remainder_out <= Dividend_in;
          end
        end
        RUN: begin
          work <= work_step;
          cnt  <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            Quotient_out  <= q_fin;
            Remainder_out <= r_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_ctrl.sv
module tb_divider_ctrl;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [31:0] Dividend_in = '0;
  logic [31:0] Divisor_in = '0;
  logic        W_ctrl, Busy, Ready, Div_by_zero;
  logic [31:0] Quotient_out, Remainder_out;

  int n_total = 0;
  int n_pass  = 0;

  divider_ctrl dut (
    .clk(clk), .Reset(Reset), .Start(Start),
    .Dividend_in(Dividend_in), .Divisor_in(Divisor_in),
    .W_ctrl(W_ctrl), .Busy(Busy), .Ready(Ready),
    .Quotient_out(Quotient_out), .Remainder_out(Remainder_out),
    .Div_by_zero(Div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // k counts falling edges after the Start-sampling edge N. k = 0 is the LOAD
  // cycle. Ready at k = 33 is cycle N+34; Ready at k = 1 is cycle N+2.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [31:0] eq, input logic [31:0] er,
                         input logic ez, input int restart_k, input int extra);
    int lat = -1;
    int wcnt = 0;
    int ovl = 0;
    int rdy_extra = 0;
    @(negedge clk);
    Dividend_in = a;
    Divisor_in  = b;
    Start       = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    for (int k = 0; k < 60 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check({tag, " load_busy"}, {31'd0, Busy}, 32'd1);
        check({tag, " load_dz_clear"}, {31'd0, Div_by_zero}, 32'd0);
      end
      if (k == restart_k + 1) begin
        Start = 1'b0;
        Dividend_in = a;
        Divisor_in  = b;
      end
      if (k == restart_k) begin
        Start       = 1'b1;
        Dividend_in = 32'h0000_1234;
        Divisor_in  = 32'd0;
      end
      wcnt += int'(W_ctrl);
      if (Busy && Ready) ovl++;
      if (Ready) lat = k;
    end
    Start = 1'b0;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " quotient"}, Quotient_out, eq);
    check({tag, " remainder"}, Remainder_out, er);
    check({tag, " div_by_zero"}, {31'd0, Div_by_zero}, {31'd0, ez});
    check({tag, " w_ctrl_cycles"}, wcnt, 32'd1);
    check({tag, " busy_ready_overlap"}, ovl, 32'd0);
    for (int j = 0; j < extra; j++) begin
      @(negedge clk);
      if (Ready) rdy_extra++;
    end
    check({tag, " extra_ready"}, rdy_extra, 32'd0);
    check({tag, " quotient_hold"}, Quotient_out, eq);
    check({tag, " idle_busy"}, {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    int rdy_cnt;
    repeat (3) @(negedge clk);
    check("reset quotient", Quotient_out, 32'd0);
    check("reset remainder", Remainder_out, 32'd0);
    check("reset flags", {28'd0, W_ctrl, Busy, Ready, Div_by_zero}, 32'd0);
    Reset = 1'b0;

    run_div("u100_7", 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, -5, 2);
    run_div("u5_0", 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'd5, 1'b1, -5, 2);
    run_div("uffff_1", 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 32'd0, 1'b0, -5, 2);
    run_div("u3_16", 32'd3, 32'd16, 33, 32'd0, 32'd3, 1'b0, -5, 2);
    run_div("u_bigdiv", 32'hFFFF_FFFF, 32'h8000_0001, 33, 32'd1, 32'h7FFF_FFFE, 1'b0, -5, 2);
    run_div("restart_ignored", 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 11, 40);

    // Reset during RUN cycle 20
    @(negedge clk);
    Dividend_in = 32'd50;
    Divisor_in  = 32'd5;
    Start       = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    repeat (22) @(negedge clk);
    check("abort running", {31'd0, Busy}, 32'd1);
    Reset = 1'b1;
    @(negedge clk);
    check("abort quotient", Quotient_out, 32'd0);
    check("abort remainder", Remainder_out, 32'd0);
    check("abort flags", {28'd0, W_ctrl, Busy, Ready, Div_by_zero}, 32'd0);
    Reset = 1'b0;
    rdy_cnt = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (Ready || Busy) rdy_cnt++;
    end
    check("abort no_ready", rdy_cnt, 32'd0);
    run_div("u9_3", 32'd9, 32'd3, 33, 32'd3, 32'd0, 1'b0, -5, 2);

`ifdef DIV_SIGNED_EN
    run_div("s-7_2", 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, -5, 2);
    run_div("s7_-2", 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1, 1'b0, -5, 2);
    run_div("smin_-1", 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, 1'b0, -5, 2);
    run_div("s-5_0", 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, -5, 2);
`else
    run_div("u_fff9_2", 32'hFFFF_FFF9, 32'd2, 33, 32'h7FFF_FFFC, 32'd1, 1'b0, -5, 2);
    run_div("u_min_ffff", 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, 1'b0, -5, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
